shot_clock_ctrl: RTL
====================

Name: shot_clock_ctrl

Overview:
- Controller that sequences the shot counter/buzzer datapath and shares it between two requesters (team A, team B).
- Owns possession and the count-down/reload sequencing, and drives the buzzer.
- Sits between the player shoot buttons and the 4-bit count display/buzzer.
- A prescaler turns clk into count ticks.

Parameters:
CNT_W, 4, width of count; SHOT_TIME must satisfy 1 <= SHOT_TIME <= 2^CNT_W-1
SHOT_TIME, 9, reload value of count
TICK_DIV, 10, clk cycles per count decrement (>=2)
BUZZ_CYCLES, 3, clk cycles buzz stays high at expiry (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins play from IDLE
stop  in  1  pulse; returns to IDLE from any state
pause  in  1  level; freezes counting while high
shoot_a  in  1  team A shoot request (level, sampled each cycle)
shoot_b  in  1  team B shoot request
count  out  CNT_W  current shot-clock value
buzz  out  1  expiry buzzer
poss  out  1  possession: 0 = team A, 1 = team B
shot_ack  out  1  one-cycle pulse on an accepted shot
running  out  1  high in RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, buzz=0, poss=0, shot_ack=0, running=0, prescaler=0. Release is synchronous to the next clk edge.
- States: IDLE, RUN, PAUSE, BUZZ. All outputs are registered.
- IDLE:
  - start=1 -> count=SHOT_TIME, prescaler=0, go to RUN.
  - Shoots and pause are ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; the tick fires on the cycle it equals TICK_DIV-1, and the prescaler then wraps to 0.
  - On a tick, count decrements.
  - When a tick makes count 0: on that same edge, go to BUZZ with buzz=1.
- Shot accept:
  - Accepted only in RUN, and only from the possessing team (shoot_a when poss=0, shoot_b when poss=1).
  - Effect: count=SHOT_TIME, prescaler=0, poss toggles, shot_ack=1 for one cycle.
  - A held shoot level is accepted once per rising edge of the request (edge-detect per team).
  - The non-possessing team's request is ignored, including when both teams request in the same cycle.
- Shot and tick in the same cycle: the shot wins and no decrement occurs.
- pause=1 in RUN:
  - Go to PAUSE; count and prescaler freeze.
  - pause=0 -> back to RUN, resuming the prescaler from its held value.
  - Shots in PAUSE are ignored, and their edge-detect state is not updated.
- BUZZ:
  - buzz=1 for exactly BUZZ_CYCLES cycles.
  - On the last cycle: buzz=0, poss toggles, count=SHOT_TIME, prescaler=0, go to RUN.
  - Shots and pause are ignored in BUZZ.
- stop=1 (any state; has priority over start, shot, tick and pause):
  - Go to IDLE, buzz=0, shot_ack=0.
  - count and poss hold their values.
- start outside IDLE is ignored.
- running=1 only in RUN.
- count never wraps below 0; all arithmetic is unsigned CNT_W bits.

Optional Feature:
SHOT_CLOCK_CTRL_TALLY_EN:
- Defined: adds outputs tally_a and tally_b (each 4 bits, reset to 0).
  - Each increments on that team's accepted shot and saturates at 15.
  - Both clear on start from IDLE.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, BUZZ=2'd3), POSS_A/POSS_B constants, default parameter values.
- One sub-module, shot_tick_div: the prescaler with clear, hold and tick outputs, parameterised by TICK_DIV.
- The FSM, shot arbitration and count register stay in shot_clock_ctrl.

Test Plan:
- Reset then start, no shots -> count=9 after start edge; count 8 after 10 RUN cycles. count=0 and buzz=1 at 90 cycles; buzz high 3 cycles; then count=9, poss=1, running=1.
- In RUN with poss=0, pulse shoot_b, then shoot_a -> shoot_b is ignored. shoot_a gives shot_ack one cycle, count=9, poss=1, prescaler restarted.
- shoot_a and shoot_b both high on the same cycle with poss=0, coinciding with a tick -> only A is accepted, count=9, no decrement, poss=1.
- pause high for 25 cycles mid-count at count=5 -> count stays 5 with running=0. After release, the next decrement happens after the remaining prescaler cycles.
- stop during BUZZ -> next edge buzz=0, state IDLE, count holds 0. A further start reloads count to 9.
- rst_n low mid-RUN (count=4, poss=1) -> count=0, poss=0, buzz=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/shot_clock_ctrl_pkg.sv
// Shared definitions for the shot-clock controller: state encoding, possession
// constants, default parameter values and the tally saturating increment.
package shot_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_BUZZ  = 2'd3
    } state_e;

    localparam logic POSS_A = 1'b0;
    localparam logic POSS_B = 1'b1;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_SHOT_TIME   = 9;
    localparam int DEF_TICK_DIV    = 10;
    localparam int DEF_BUZZ_CYCLES = 3;

    localparam int TALLY_W = 4;

    function automatic logic [TALLY_W-1:0] tally_sat_inc(input logic [TALLY_W-1:0] v);
        return (v == {TALLY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/shot_tick_div.sv
// Count-tick prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise,
// and flags a tick on the cycle it sits at TICK_DIV-1.
module shot_tick_div #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign tick = en && (presc_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock controller: possession arbitration, count-down/reload and buzzer.
// Optional per-team shot tallies are enabled with SHOT_CLOCK_CTRL_TALLY_EN.
module shot_clock_ctrl
    import shot_clock_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SHOT_TIME   = DEF_SHOT_TIME,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int BUZZ_CYCLES = DEF_BUZZ_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             shoot_a,
    input  logic             shoot_b,
    output logic [CNT_W-1:0] count,
    output logic             buzz,
    output logic             poss,
    output logic             shot_ack,
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
    output logic [TALLY_W-1:0] tally_a,
    output logic [TALLY_W-1:0] tally_b,
`endif
    output logic             running
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SHOT_TIME);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             buzz_q, buzz_d;
    logic             poss_q, poss_d;
    logic             ack_q, ack_d;
    logic             run_q, run_d;
    logic             sa_prev_q, sa_prev_d;
    logic             sb_prev_q, sb_prev_d;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
    logic [TALLY_W-1:0] tally_a_q, tally_a_d;
    logic [TALLY_W-1:0] tally_b_q, tally_b_d;
`endif

    logic presc_clr;
    logic presc_en;
    logic tick;
    logic rise_a;
    logic rise_b;
    logic accept;

    shot_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    assign rise_a   = shoot_a & ~sa_prev_q;
    assign rise_b   = shoot_b & ~sb_prev_q;
    // Prescaler only advances in RUN when nothing higher-priority freezes it.
    assign presc_en = (state_q == ST_RUN) && !stop && !pause;
    assign accept   = presc_en && ((poss_q == POSS_A) ? rise_a : rise_b);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bcnt_d    = bcnt_q;
        buzz_d    = buzz_q;
        poss_d    = poss_q;
        ack_d     = 1'b0;
        presc_clr = 1'b0;
        sa_prev_d = (state_q == ST_PAUSE) ? sa_prev_q : shoot_a;
        sb_prev_d = (state_q == ST_PAUSE) ? sb_prev_q : shoot_b;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
        tally_a_d = tally_a_q;
        tally_b_d = tally_b_q;
`endif
        if (stop) begin
            state_d = ST_IDLE;
            buzz_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_d   = RELOAD;
                        presc_clr = 1'b1;
                        state_d   = ST_RUN;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
                        tally_a_d = '0;
                        tally_b_d = '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (accept) begin
                        count_d   = RELOAD;
                        presc_clr = 1'b1;
                        poss_d    = ~poss_q;
                        ack_d     = 1'b1;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
                        if (poss_q == POSS_A) tally_a_d = tally_sat_inc(tally_a_q);
                        else                  tally_b_d = tally_sat_inc(tally_b_q);
`endif
                    end else if (tick && (count_q != '0)) begin
                        count_d = count_q - 1'b1;
                        if (count_q == ONE) begin
                            state_d = ST_BUZZ;
                            buzz_d  = 1'b1;
                            bcnt_d  = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_d = ST_RUN;
                end
                ST_BUZZ: begin
                    if (bcnt_q == BUZZ_LAST) begin
                        buzz_d    = 1'b0;
                        poss_d    = ~poss_q;
                        count_d   = RELOAD;
                        presc_clr = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        run_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            bcnt_q    <= '0;
            buzz_q    <= 1'b0;
            poss_q    <= POSS_A;
            ack_q     <= 1'b0;
            run_q     <= 1'b0;
            sa_prev_q <= 1'b0;
            sb_prev_q <= 1'b0;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
            tally_a_q <= '0;
            tally_b_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bcnt_q    <= bcnt_d;
            buzz_q    <= buzz_d;
            poss_q    <= poss_d;
            ack_q     <= ack_d;
            run_q     <= run_d;
            sa_prev_q <= sa_prev_d;
            sb_prev_q <= sb_prev_d;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
            tally_a_q <= tally_a_d;
            tally_b_q <= tally_b_d;
`endif
        end
    end

    assign count    = count_q;
    assign buzz     = buzz_q;
    assign poss     = poss_q;
    assign shot_ack = ack_q;
    assign running  = run_q;
`ifdef SHOT_CLOCK_CTRL_TALLY_EN
    assign tally_a  = tally_a_q;
    assign tally_b  = tally_b_q;
`endif

endmodule
